// File: rtl/relu_pkg.sv
// relu_pkg: shared state encoding and datapath constants for the ReLU scheduler
package relu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int LATENCY = 2;
  localparam int DEF_NUM_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/relu.sv
// relu: LATENCY-stage ReLU/bypass datapath; data registers are intentionally unreset
module relu
  import relu_pkg::*;
#(
  parameter int NUM_WIDTH = DEF_NUM_WIDTH
) (
  input  logic                 clk,
  input  logic [NUM_WIDTH-1:0] up_data,
  input  logic                 up_bypass,
  output logic [NUM_WIDTH-1:0] dn_data
);
  logic [NUM_WIDTH-1:0] pipe_d [LATENCY];
  logic [NUM_WIDTH-1:0] pipe_q [LATENCY];
  // first stage clamps negatives unless bypassed; later stages only delay
  always_comb begin
    pipe_d[0] = (up_bypass || !up_data[NUM_WIDTH-1]) ? up_data : '0;
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end
  // pipeline registers, qualified downstream by the scheduler's tag valids
  always_ff @(posedge clk) pipe_q <= pipe_d;
  assign dn_data = pipe_q[LATENCY-1];
endmodule

// File: rtl/relu_sched.sv
// relu_sched: command-driven ReLU scheduler with credit-limited output FIFO
module relu_sched
  import relu_pkg::*;
#(
  parameter int NUM_WIDTH  = DEF_NUM_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_bypass,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [NUM_WIDTH-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [NUM_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic byp_q, byp_d;
  logic [LATENCY-1:0] tv_q, tv_d, tl_q, tl_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [NUM_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [NUM_WIDTH-1:0] dn_data;
  logic s_fire, wr, rd;
  int inflight;
  relu #(.NUM_WIDTH(NUM_WIDTH)) u_relu (
    .clk      (clk),
    .up_data  (s_data),
    .up_bypass(byp_q),
    .dn_data  (dn_data)
  );
  // handshakes: inputs are credited against FIFO space plus results still in the pipeline
  always_comb begin
    inflight = 0;
    for (int i = 0; i < LATENCY; i++) inflight += int'(tv_q[i]);
    cmd_ready = !rst && state_q == IDLE;
    busy = !rst && state_q != IDLE;
    done = !rst && state_q == DONE;
    s_ready = !rst && state_q == RUN && rem_q != '0 && int'(cnt_q) + inflight < FIFO_DEPTH;
    m_valid = !rst && cnt_q != '0;
    m_data = mem_q[rp_q][NUM_WIDTH-1:0];
    m_last = m_valid && mem_q[rp_q][NUM_WIDTH];
    s_fire = s_valid && s_ready;
    rd = m_valid && m_ready;
    wr = tv_q[LATENCY-1];
  end
  // next state, command latch, tag pipeline and FIFO bookkeeping
  always_comb begin
    state_d = state_q;
    byp_d = byp_q;
    rem_d = s_fire ? rem_q - LEN_WIDTH'(1) : rem_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        byp_d = cmd_bypass;
        rem_d = cmd_len;
        state_d = cmd_len == '0 ? DONE : RUN;
      end
      RUN: if (s_fire && rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
      DRAIN: if (rd && m_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
    tv_d = {tv_q[LATENCY-2:0], s_fire};
    tl_d = {tl_q[LATENCY-2:0], rem_q == LEN_WIDTH'(1)};
    wp_d = wp_q + AW'(wr);
    rp_d = rp_q + AW'(rd);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  // control registers; reset discards any in-flight or buffered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      byp_q <= 1'b0;
      tv_q <= '0;
      tl_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      byp_q <= byp_d;
      tv_q <= tv_d;
      tl_q <= tl_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // FIFO storage, written when a tag leaves the pipeline
  always_ff @(posedge clk) if (wr) mem_q[wp_q] <= {tl_q[LATENCY-1], dn_data};
endmodule

// File: tb/tb_relu_sched.sv
// tb_relu_sched: randomized and directed checks of relu_sched against a queue-based model
module tb_relu_sched;
  localparam int W = 16;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_bypass = 0, s_valid = 0, m_ready = 0;
  logic [15:0] cmd_len = 0;
  logic [W-1:0] s_data = 0;
  logic cmd_ready, s_ready, m_valid, m_last, busy, done;
  logic [W-1:0] m_data;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [W:0] exp_q[$];
  logic [W-1:0] data_q[$];
  int model_rem, accepted, outs, lasts, dones, last_cyc, done_cyc, acc_cyc, mv_cyc;
  logic model_byp;
  logic hold = 0, hold_l;
  logic [W-1:0] hold_d;

  relu_sched dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_bypass(cmd_bypass), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] ref_val(input logic [W-1:0] x, input logic b);
    return (b || $signed(x) >= 0) ? x : '0;
  endfunction

  task automatic step(input logic sv, input logic mr);
    logic [W:0] e;
    if (data_q.size() == 0) data_q.push_back(W'($urandom));
    s_valid = sv; s_data = data_q[0]; m_ready = mr;
    #1;
    if (hold) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, hold_d);
      chk("hold_last", m_last, hold_l);
    end
    if (s_valid && s_ready) begin
      exp_q.push_back({model_rem == 1, ref_val(s_data, model_byp)});
      model_rem--; accepted++;
      if (accepted == 1) acc_cyc = cyc;
      void'(data_q.pop_front());
    end
    if (m_valid && mv_cyc < 0) mv_cyc = cyc;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", m_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("m_data", m_data, e[W-1:0]);
        chk("m_last", m_last, e[W]);
      end
      outs++;
      if (m_last) begin lasts++; last_cyc = cyc; end
    end
    if (done) begin dones++; done_cyc = cyc; end
    hold = m_valid && !m_ready; hold_d = m_data; hold_l = m_last;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic send_cmd(input int len, input logic byp);
    model_rem = len; model_byp = byp;
    accepted = 0; outs = 0; lasts = 0; dones = 0;
    last_cyc = -1; done_cyc = -1; acc_cyc = -1; mv_cyc = -1;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_len = 16'(len); cmd_bypass = byp;
    step(0, 1);
    cmd_valid = 0;
  endtask

  task automatic run(input int len, input int pv, input int pm);
    for (int n = 0; n < 3000 && !(outs == len && dones > 0); n++)
      step($urandom_range(99) < pv, $urandom_range(99) < pm);
    chk("outs", outs, len);
    chk("lasts", lasts, len > 0 ? 1 : 0);
    chk("dones", dones, 1);
    chk("exp_empty", exp_q.size(), 0);
    if (len > 0) begin
      chk("done_after_last", done_cyc, last_cyc + 1);
      chk("latency", mv_cyc - acc_cyc, 3);
    end
    chk("busy_after", busy, 0);
    chk("cmd_ready_after", cmd_ready, 1);
    chk("m_valid_after", m_valid, 0);
    data_q.delete();
  endtask

  initial begin
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0; #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    data_q = '{16'h0005, 16'hFFFB, 16'h7FFF};
    send_cmd(3, 0); run(3, 100, 100);
    data_q = '{16'h8000, 16'hFFFF, 16'h8001, 16'h1234};
    send_cmd(4, 1); run(4, 100, 100);
    data_q = '{16'h8000, 16'h0001, 16'hFFFF, 16'h0000};
    send_cmd(4, 0); run(4, 100, 100);
    send_cmd(8, 0);
    repeat (12) step(1, 0);
    chk("stall_accepted", accepted, 4);
    chk("stall_s_ready", s_ready, 0);
    chk("stall_m_valid", m_valid, 1);
    run(8, 100, 100);
    send_cmd(0, 0);
    chk("len0_busy", busy, 1);
    chk("len0_done", done, 1);
    chk("len0_m_valid", m_valid, 0);
    run(0, 100, 100);
    send_cmd(5, 0);
    for (int n = 0; n < 20 && accepted < 2; n++) step(1, 0);
    chk("abort_accepted", accepted, 2);
    rst = 1; #1;
    chk("abort_rst_cmd_ready", cmd_ready, 0);
    chk("abort_rst_busy", busy, 0);
    step(0, 0); step(0, 0);
    rst = 0; exp_q.delete(); hold = 0; dones = 0;
    for (int n = 0; n < 6; n++) begin
      chk("abort_m_valid", m_valid, 0);
      chk("abort_done", done, 0);
      step(0, 1);
    end
    data_q.delete();
    send_cmd(1, 0); run(1, 100, 100);
    send_cmd(100, 0); run(100, 60, 50);
    send_cmd(37, 1); run(37, 80, 30);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
